// File: rtl/hier_leaf_dispatch.sv
// ---------------------------------------------------------------------------
// hier_leaf_dispatch
//
// Dispatch stage in front of a leaf fan-out group. One valid/ready input
// stream is buffered in a 2-entry FIFO that feeds a 1-entry output register.
// Each word goes to exactly one child channel, in strict round-robin order.
// A stalled target blocks the stream: the stage never skips ahead.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream word valid
//   in_ready   stage can accept a word (registered, fifo_count < 2)
//   in_data    upstream word
//   out_valid  one-hot valid, bit i addresses child i
//   out_ready  per-child ready; only the targeted child's bit is used
//   out_data   word shared by all children; holds its value while idle
//   out_idx    index of the targeted child
//   disp_cnt   wrapping count of dispatched words
//   stall_cnt  wrapping count of cycles with a word waiting on its target
// ---------------------------------------------------------------------------
module hier_leaf_dispatch #(
   parameter int DATA_W    = 16,
   parameter int NUM_CHILD = 5,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   output logic [NUM_CHILD-1:0] out_valid,
   input  logic [NUM_CHILD-1:0] out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [2:0]           out_idx,
   output logic [CNT_W-1:0]     disp_cnt,
   output logic [CNT_W-1:0]     stall_cnt
);

   // 2-entry FIFO storage and pointers
   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_count;
   logic [1:0]        count_nxt;
   logic              ready_r;

   // output register
   logic              valid_r;
   logic [DATA_W-1:0] data_r;
   logic [2:0]        tgt_r;
   logic [2:0]        rr_ptr;
   logic [2:0]        rr_nxt;

   // handshake decode
   logic tgt_ready;
   logic in_xfer;
   logic out_xfer;
   logic load;
   logic fifo_pop;
   logic fifo_push;
   logic bypass;

   // Select the ready bit of the targeted child; all other bits are ignored.
   always_comb begin
      // NOTE: assigning a default before the loop keeps this purely
      // combinational; a path that leaves it unassigned would infer a latch.
      tgt_ready = 1'b0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         if (tgt_r == 3'(i)) tgt_ready = out_ready[i];
      end
   end

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         out_valid[i] = valid_r && (tgt_r == 3'(i));
      end
   end

   assign in_xfer   = in_valid && ready_r;
   assign out_xfer  = valid_r && tgt_ready;
   // The register reloads whenever it is empty or its word leaves this cycle.
   assign load      = !valid_r || out_xfer;
   // FIFO head has priority; the input only bypasses when the FIFO is empty,
   // so a word is never presented from both paths at once.
   assign fifo_pop  = load && (fifo_count != 2'd0);
   assign bypass    = load && (fifo_count == 2'd0) && in_xfer;
   assign fifo_push = in_xfer && !bypass;
   assign count_nxt = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};

   // A word loaded in the same cycle as a transfer targets the next child.
   always_comb begin
      rr_nxt = rr_ptr;
      if (out_xfer) begin
         rr_nxt = (rr_ptr == 3'(NUM_CHILD - 1)) ? 3'd0 : rr_ptr + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
         ready_r    <= 1'b1;
         valid_r    <= 1'b0;
         data_r     <= '0;
         tgt_r      <= 3'd0;
         rr_ptr     <= 3'd0;
         disp_cnt   <= '0;
         stall_cnt  <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         if (fifo_push) wr_ptr <= ~wr_ptr;
         if (fifo_pop)  rd_ptr <= ~rd_ptr;
         fifo_count <= count_nxt;
         // Registered from the next count, so in_ready never depends
         // combinationally on out_ready.
         ready_r    <= (count_nxt < 2'd2);
         rr_ptr     <= rr_nxt;
         if (load) valid_r <= fifo_pop || bypass;
         if (fifo_pop) begin
            data_r <= fifo_mem[rd_ptr];
            tgt_r  <= rr_nxt;
         end else if (bypass) begin
            data_r <= in_data;
            tgt_r  <= rr_nxt;
         end
         if (out_xfer)              disp_cnt  <= disp_cnt + CNT_W'(1);
         if (valid_r && !tgt_ready) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // NOTE: FIFO storage has no reset; an entry is only ever read after it
   // has been written, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr] <= in_data;
   end

   assign in_ready = ready_r;
   assign out_data = data_r;
   assign out_idx  = tgt_r;

endmodule
